// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg : opcode constants, FSM state codes and opcode classes    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LDO  = 4'b0001;
    localparam logic [3:0] OP_LDA  = 4'b0010;
    localparam logic [3:0] OP_STO  = 4'b0011;
    localparam logic [3:0] OP_PRE  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_LDM  = 4'b0110;
    localparam logic [3:0] OP_HLT  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_SLEF = 4'b1010;
    localparam logic [3:0] OP_SRIG = 4'b1011;
    localparam logic [3:0] OP_SUB  = 4'b1100;
    localparam logic [3:0] OP_INC  = 4'b1101;
    localparam logic [3:0] OP_DEC  = 4'b1110;
    localparam logic [3:0] OP_XOR  = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH_HI = 3'd0,
        S_FETCH_LO = 3'd1,
        S_DECODE   = 3'd2,
        S_OPERAND  = 3'd3,
        S_EXEC     = 3'd4,
        S_WRAP     = 3'd5,
        S_HALT     = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_MEM   = 3'd1,
        CLS_IMM   = 3'd2,
        CLS_STORE = 3'd3,
        CLS_HALT  = 3'd4
    } op_class_e;

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_ctrl_if : controller <-> datapath strobe bundle               |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface cpu_ctrl_if #(
    parameter int STATE_W = 3
);
    logic               ena;
    logic [3:0]         opcode;
    logic [3:0]         alu_op;
    logic               rd;
    logic               wr;
    logic               load_ir_hi;
    logic               load_ir_lo;
    logic               inc_pc;
    logic               load_acc;
    logic               datactl_ena;
    logic               halt;
    logic [STATE_W-1:0] state;

    // master = controller, slave = datapath consuming the strobes
    modport master (
        input  ena, opcode,
        output alu_op, rd, wr, load_ir_hi, load_ir_lo, inc_pc,
               load_acc, datactl_ena, halt, state
    );

    modport slave (
        output ena, opcode,
        input  alu_op, rd, wr, load_ir_hi, load_ir_lo, inc_pc,
               load_acc, datactl_ena, halt, state
    );
endinterface
`default_nettype wire

// File: rtl/cpu_op_class.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_op_class : combinational opcode -> execution class map        |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module cpu_op_class
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_e  op_class
);
    always_comb begin
        op_class = CLS_NONE;
        case (opcode)
            OP_LDO, OP_ADD, OP_AND, OP_OR,
            OP_SUB, OP_XOR, OP_PRE:          op_class = CLS_MEM;
            OP_LDA, OP_INC, OP_DEC:          op_class = CLS_IMM;
            OP_STO, OP_LDM:                  op_class = CLS_STORE;
            OP_HLT:                          op_class = CLS_HALT;
            default:                         op_class = CLS_NONE;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_ctrl : six-step fetch/decode/execute sequencer, Moore outputs |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int STATE_W = 3
) (
    input  logic      clk,
    input  logic      rst,
    cpu_ctrl_if.master bus
);
    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    op_class_e  cls;
    logic [2:0] state_code;

    logic [3:0] alu_op_o;
    logic       rd_o, wr_o, ir_hi_o, ir_lo_o, inc_pc_o, acc_o, dat_o, halt_o;

    cpu_op_class u_op_class (
        .opcode   (op_q),
        .op_class (cls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH_HI;
            op_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        if (state_q == S_HALT) begin
            state_d = S_HALT;
        end else if (bus.ena) begin
            case (state_q)
                S_FETCH_HI: state_d = S_FETCH_LO;
                S_FETCH_LO: state_d = S_DECODE;
                S_DECODE: begin
                    if (bus.opcode == OP_HLT) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_OPERAND;
                        op_d    = bus.opcode;
                    end
                end
                S_OPERAND:  state_d = S_EXEC;
                S_EXEC:     state_d = S_WRAP;
                S_WRAP:     state_d = S_FETCH_HI;
                default:    state_d = S_FETCH_HI;
            endcase
        end
    end

    // Reset gates the decode so strobes drop in the same cycle rst rises
    always_comb begin
        alu_op_o = OP_NOP;
        rd_o     = 1'b0;
        wr_o     = 1'b0;
        ir_hi_o  = 1'b0;
        ir_lo_o  = 1'b0;
        inc_pc_o = 1'b0;
        acc_o    = 1'b0;
        dat_o    = 1'b0;
        halt_o   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH_HI: begin
                    rd_o     = 1'b1;
                    ir_hi_o  = 1'b1;
                    inc_pc_o = 1'b1;
                end
                S_FETCH_LO: begin
                    rd_o     = 1'b1;
                    ir_lo_o  = 1'b1;
                    inc_pc_o = 1'b1;
                end
                S_OPERAND, S_EXEC, S_WRAP: begin
                    if (cls == CLS_MEM || cls == CLS_IMM || cls == CLS_STORE)
                        alu_op_o = op_q;
                    if (cls == CLS_MEM && state_q != S_WRAP)
                        rd_o = 1'b1;
                    if (state_q == S_EXEC && cls == CLS_MEM && op_q != OP_PRE)
                        acc_o = 1'b1;
                    if (state_q == S_EXEC && cls == CLS_IMM)
                        acc_o = 1'b1;
                    if (cls == CLS_STORE) begin
                        dat_o = 1'b1;
                        wr_o  = (state_q == S_EXEC);
                    end
                end
                S_HALT:  halt_o = 1'b1;
                default: halt_o = 1'b0;
            endcase
        end
    end

    assign state_code      = state_q;
    assign bus.state       = STATE_W'(state_code);
    assign bus.alu_op      = alu_op_o;
    assign bus.rd          = rd_o;
    assign bus.wr          = wr_o;
    assign bus.load_ir_hi  = ir_hi_o;
    assign bus.load_ir_lo  = ir_lo_o;
    assign bus.inc_pc      = inc_pc_o;
    assign bus.load_acc    = acc_o;
    assign bus.datactl_ena = dat_o;
    assign bus.halt        = halt_o;

endmodule
`default_nettype wire
